// File: rtl/uart_rx_ip.sv
// UART receiver with a small receive FIFO and a register interface.
// 8N1 framing, mid-bit sampling, programmable clocks-per-bit divisor.
module uart_rx_ip #(
  parameter logic [15:0] CLK_DIV_DEFAULT = 16'd434,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_uart_rx,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_sync1, r_sync2, r_rx_prev, r_armed;
  logic [1:0]     r_settle;
  logic [15:0]    r_cnt, w_cnt_nxt, r_div_lat, w_div_nxt, r_divisor, w_div_eff;
  logic [2:0]     r_bit_idx, w_bit_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           w_push, w_ferr_set, w_rx, w_fall, w_expire;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_overrun, r_frame_err;
  logic           w_full, w_not_empty, w_pop, w_fifo_wr, w_ovr_set;
  logic           w_wr_acc, w_stat_wr;
  logic [31:0]    w_status;
  logic           w_unused;

  assign w_rx      = r_sync2;
  // A start edge only counts once the line has genuinely been seen high after reset,
  // so a frame interrupted by reset cannot be mistaken for a new start bit.
  assign w_fall    = r_armed & r_rx_prev & ~w_rx;
  assign w_expire  = (r_cnt == 16'd0);
  assign w_div_eff = (r_divisor < 16'd4) ? 16'd4 : r_divisor;

  assign w_full      = (r_count == DEPTH_C);
  assign w_not_empty = (r_count != '0);
  assign w_pop       = ren & (raddr[3:2] == 2'd0) & w_not_empty;
  assign w_fifo_wr   = w_push & (~w_full | w_pop);
  assign w_ovr_set   = w_push & w_full & ~w_pop;
  assign w_wr_acc    = wen & wstrb[0];
  assign w_stat_wr   = w_wr_acc & (waddr[3:2] == 2'd1);
  assign w_status    = {28'd0, r_frame_err, r_overrun, w_full, w_not_empty};
  assign o_irq       = w_not_empty | r_overrun | r_frame_err;
  assign w_unused    = &{1'b0, waddr[31:4], waddr[1:0], wdata[31:16], wstrb[3:1],
                         raddr[31:4], raddr[1:0]};

  // Line synchronizer, edge history and post-reset arming.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_settle  <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= i_uart_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_settle  <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_rx) r_armed <= 1'b1;
    end
  end

  // Receiver FSM state and bit-timing control registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
    end
  end

  // Shift register and per-frame divisor latch.
  always_ff @(posedge clk) begin
    r_shift   <= w_shift_nxt;
    r_div_lat <= w_div_nxt;
  end

  // Next-state logic: counter expiry marks each sample point, div cycles apart.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div_lat;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_div_nxt   = w_div_eff;
          w_cnt_nxt   = (w_div_eff >> 1) - 16'd1;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (!w_rx) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = r_div_lat - 16'd1;
            w_bit_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_cnt_nxt   = r_div_lat - 16'd1;
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          if (w_rx) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; on a simultaneous push and pop while full the read sees the old head.
  always_ff @(posedge clk) begin
    if (w_fifo_wr) r_mem[r_wptr] <= r_shift;
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_fifo_wr) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_fifo_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: hardware set wins over a same-cycle W1C clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_ovr_set  | (r_overrun   & ~(w_stat_wr & wdata[2]));
      r_frame_err <= w_ferr_set | (r_frame_err & ~(w_stat_wr & wdata[3]));
    end
  end

  // Register write port: DIVISOR update and one-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_divisor <= CLK_DIV_DEFAULT;
      wready    <= 1'b0;
    end else begin
      wready <= wen;
      if (w_wr_acc && waddr[3:2] == 2'd2) r_divisor <= wdata[15:0];
    end
  end

  // Register read port: registered data with a one-cycle valid; rdata holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata  <= 32'd0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren) begin
        case (raddr[3:2])
          2'd0:    rdata <= w_not_empty ? {24'd0, r_mem[r_rptr]} : 32'd0;
          2'd1:    rdata <= w_status;
          2'd2:    rdata <= {16'd0, r_divisor};
          default: rdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ip.sv
// Directed and randomized bench for uart_rx_ip with a queue-based receiver model.
module tb_uart_rx_ip;

  localparam logic [15:0] DEF_DIV = 16'd434;
  localparam int          DEPTH   = 4;

  logic        clk;
  logic        reset_n;
  logic        uart_rx;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        wen, ren, wready, rvalid, irq;
  logic [3:0]  wstrb;

  int checks   = 0;
  int failures = 0;

  // Reference model: received bytes, sticky flags, programmed divisor.
  logic [7:0] mq[$];
  logic       m_ovr, m_ferr;
  int         m_div;

  uart_rx_ip #(.CLK_DIV_DEFAULT(DEF_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_uart_rx(uart_rx),
    .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = {28'd0, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    return s;
  endfunction

  function automatic int bit_len(input int div);
    return (div < 4) ? 4 : div;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_div  = int'(DEF_DIV);
  endtask

  task automatic m_frame(input logic [7:0] b, input logic stop);
    if (!stop)                 m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else                       mq.push_back(b);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    waddr = a; wdata = d; wstrb = s; wen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0;
    check("wready", {31'd0, wready}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    raddr = a; ren = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0;
    check("rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
    @(negedge clk);
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] d, ms;
    rd(32'h4, d);
    ms = m_status();
    check(tag, d, ms);
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, ms[0] | ms[2] | ms[3]});
  endtask

  task automatic data_chk(input string tag);
    logic [31:0] d, e;
    rd(32'h0, d);
    e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
    check(tag, d, e);
  endtask

  // Serial frame driver. mode 1: DATA read timed onto the stop-bit sample edge
  // (start edge seen 2 clocks late through the synchronizer, sample at half a bit);
  // mode 2: one-cycle reset pulse in the middle of data bit 3.
  task automatic send(input logic [7:0] b, input logic stop, input int bitlen,
                      input int mode, output logic [31:0] popped);
    logic [9:0] fr;
    int h;
    fr = {stop, b, 1'b0};
    h = bitlen / 2;
    popped = 32'd0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      uart_rx = fr[j];
      if (j == 9 && mode == 1) begin
        repeat (2 + h) @(posedge clk);
        @(negedge clk);
        raddr = 32'h0; ren = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ren = 1'b0;
        check("stop_pop_rvalid", {31'd0, rvalid}, 32'd1);
        popped = rdata;
        repeat (bitlen - h - 3) @(posedge clk);
      end else if (j == 4 && mode == 2) begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (bitlen - 6) @(posedge clk);
      end else begin
        repeat (bitlen) @(posedge clk);
      end
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * bitlen) @(posedge clk);
  endtask

  initial begin
    logic [31:0] d, p;
    int div;
    logic [7:0] b;
    logic stp;

    reset_n = 1'b0; uart_rx = 1'b1;
    waddr = '0; wdata = '0; wstrb = '0; wen = 1'b0;
    raddr = '0; ren = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    status_chk("rst_status");
    rd(32'h8, d); check("rst_divisor", d, {16'd0, DEF_DIV});

    // Register access basics
    wr(32'h8, 32'd16, 4'b0001); m_div = 16;
    rd(32'h8, d); check("div_write", d, 32'd16);
    wr(32'h8, 32'h1234, 4'b1110);
    rd(32'h8, d); check("div_no_strb", d, 32'd16);
    wr(32'hC, 32'hFFFF_FFFF, 4'b1111);
    rd(32'hC, d); check("reg_c_zero", d, 32'd0);
    data_chk("empty_read");

    // Single frame 0xA5
    send(8'hA5, 1'b1, 16, 0, p); m_frame(8'hA5, 1'b1);
    rd(32'h4, d); check("a5_status", d, 32'h1);
    check("a5_irq", {31'd0, irq}, 32'd1);
    data_chk("a5_data");
    status_chk("a5_status_after");
    data_chk("a5_empty_read");

    // 4-cycle glitch on an idle line
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    status_chk("glitch_status");
    send(8'h96, 1'b1, 16, 0, p); m_frame(8'h96, 1'b1);
    data_chk("post_glitch_data");

    // Framing error on 0x3C
    send(8'h3C, 1'b0, 16, 0, p); m_frame(8'h3C, 1'b0);
    rd(32'h4, d); check("ferr_status", d, 32'h8);
    wr(32'h4, 32'h8, 4'b0001); m_ferr = 1'b0;
    status_chk("ferr_cleared");

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, 16, 0, p); m_frame(8'(i), 1'b1);
    end
    rd(32'h4, d); check("ovr_status", d, 32'h7);
    for (int i = 0; i < 4; i++) data_chk("ovr_drain");
    rd(32'h4, d); check("ovr_status_after", d, 32'h4);
    wr(32'h4, 32'h4, 4'b0001); m_ovr = 1'b0;
    status_chk("ovr_cleared");

    // Full FIFO with pop coinciding with the stop-bit push of 0x77
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i), 1'b1, 16, 0, p); m_frame(8'h10 + 8'(i), 1'b1);
    end
    status_chk("full_status");
    send(8'h77, 1'b1, 16, 1, p);
    check("coincident_pop", p, {24'd0, mq.pop_front()});
    m_frame(8'h77, 1'b1);
    status_chk("coincident_no_ovr");
    for (int i = 0; i < 4; i++) data_chk("coincident_drain");
    status_chk("coincident_empty");

    // Divisor below the minimum runs at 4 clocks per bit
    wr(32'h8, 32'd2, 4'b0001); m_div = 2;
    rd(32'h8, d); check("div_small_readback", d, 32'd2);
    send(8'hC3, 1'b1, bit_len(m_div), 0, p); m_frame(8'hC3, 1'b1);
    data_chk("clamp_data");

    // Randomized frames, divisors, reads and flag clears
    for (int i = 0; i < 16; i++) begin
      div = int'($urandom_range(1, 24));
      wr(32'h8, 32'(div), 4'b0001); m_div = div;
      b   = 8'($urandom);
      stp = ($urandom_range(0, 5) != 0);
      send(b, stp, bit_len(m_div), 0, p); m_frame(b, stp);
      status_chk("rand_status");
      if ($urandom_range(0, 1) == 1) data_chk("rand_data");
      if ($urandom_range(0, 3) == 0) begin
        wr(32'h4, 32'hC, 4'b0001); m_ovr = 1'b0; m_ferr = 1'b0;
      end
    end

    // Reset in the middle of frame 0xF0, then a clean 0x5A at the default divisor
    wr(32'h8, 32'd16, 4'b0001); m_div = 16;
    send(8'h11, 1'b1, 16, 0, p); m_frame(8'h11, 1'b1);
    send(8'h22, 1'b1, 16, 0, p); m_frame(8'h22, 1'b1);
    send(8'hF0, 1'b1, 16, 2, p); m_reset();
    status_chk("midreset_status");
    rd(32'h8, d); check("midreset_divisor", d, {16'd0, DEF_DIV});
    send(8'h5A, 1'b1, m_div, 0, p); m_frame(8'h5A, 1'b1);
    rd(32'h4, d); check("post_reset_status", d, 32'h1);
    data_chk("post_reset_data");
    status_chk("final_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
